// File: rtl/gate_seq_pkg.sv
// Shared constants for gate_demux_sequencer: FSM encoding, step count and result bit map.
package gate_seq_pkg;

   typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

   localparam int unsigned NUM_STEPS = 9;
   // Extra EVAL cycle after the last demux step that commits the scratch result.
   localparam logic [3:0] COMMIT_STEP = 4'(NUM_STEPS);

   localparam int unsigned IDX_AND  = 0;
   localparam int unsigned IDX_NOT  = 1;
   localparam int unsigned IDX_OR   = 2;
   localparam int unsigned IDX_NAND = 3;
   localparam int unsigned IDX_NOR  = 4;
   localparam int unsigned IDX_XOR  = 5;
   localparam int unsigned IDX_XNOR = 6;

endpackage

// File: rtl/demux1_4.sv
// 1-to-4 demultiplexer: routes in to out[sel], all other outputs low.
module demux1_4 (
   input  logic       in,
   input  logic [1:0] sel,
   output logic [3:0] out
);

   always_comb begin
      out      = 4'b0000;
      out[sel] = in;
   end

endmodule

// File: rtl/gate_demux_sequencer.sv
// Evaluates seven boolean functions of (a, b) by time-multiplexing one demux1_4.
// Optional macro GATE_SEQ_SELF_CHECK_EN adds a sticky result self-check on err.
module gate_demux_sequencer
   import gate_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       a,
   input  logic       b,
   output logic       busy,
   output logic       done,
   output logic [6:0] result,
   output logic [3:0] step,
   output logic       err
);

   state_e     state_q, state_d;
   logic [3:0] step_q, step_d;
   logic       op_a_q, op_a_d, op_b_q, op_b_d;
   logic [3:0] m_q, m_d;
   logic       t_q, t_d, u_q, u_d;
   logic [6:0] res_q, res_d;
   logic [6:0] result_q, result_d;
   logic       done_q, done_d, busy_q, busy_d;
   logic [1:0] sel;
   logic [3:0] dmx_out;
   logic       accept;

   demux1_4 u_demux (
      .in  (1'b1),
      .sel (sel),
      .out (dmx_out)
   );

   // With in tied high the demux output is a one-hot decode of sel.
   always_comb begin
      sel = 2'b00;
      if (state_q == StEval) begin
         case (step_q)
            4'd0:    sel = {op_a_q, op_b_q};
            4'd1:    sel = {op_a_q, 1'b0};
            4'd2:    sel = {m_q[0], 1'b0};
            4'd3:    sel = {m_q[3], 1'b0};
            4'd4:    sel = {res_q[IDX_OR], 1'b0};
            4'd5:    sel = {m_q[1], m_q[2]};
            4'd6:    sel = {t_q, 1'b0};
            4'd7:    sel = {m_q[0], m_q[3]};
            4'd8:    sel = {u_q, 1'b0};
            default: sel = 2'b00;
         endcase
      end
   end

   assign accept = start && (state_q == StIdle || state_q == StDone);

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      m_d      = m_q;
      t_d      = t_q;
      u_d      = u_q;
      res_d    = res_q;
      result_d = result_q;
      done_d   = 1'b0;
      unique case (state_q)
         StEval: begin
            case (step_q)
               4'd0: begin
                  m_d            = dmx_out;
                  res_d[IDX_AND] = dmx_out[3];
               end
               4'd1:    res_d[IDX_NOT]  = dmx_out[0];
               4'd2:    res_d[IDX_OR]   = dmx_out[0];
               4'd3:    res_d[IDX_NAND] = dmx_out[0];
               4'd4:    res_d[IDX_NOR]  = dmx_out[0];
               4'd5:    t_d             = dmx_out[0];
               4'd6:    res_d[IDX_XOR]  = dmx_out[0];
               4'd7:    u_d             = dmx_out[0];
               4'd8:    res_d[IDX_XNOR] = dmx_out[0];
               default: ;
            endcase
            if (step_q == COMMIT_STEP) begin
               state_d  = StDone;
               step_d   = 4'd0;
               result_d = res_q;
               done_d   = 1'b1;
            end else begin
               step_d = step_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (accept) begin
         state_d = StEval;
         step_d  = 4'd0;
         op_a_d  = a;
         op_b_d  = b;
         m_d     = 4'b0000;
         t_d     = 1'b0;
         u_d     = 1'b0;
         res_d   = 7'b0000000;
      end
      busy_d = (state_d == StEval);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         step_q   <= 4'd0;
         op_a_q   <= 1'b0;
         op_b_q   <= 1'b0;
         m_q      <= 4'b0000;
         t_q      <= 1'b0;
         u_q      <= 1'b0;
         res_q    <= 7'b0000000;
         result_q <= 7'b0000000;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         m_q      <= m_d;
         t_q      <= t_d;
         u_q      <= u_d;
         res_q    <= res_d;
         result_q <= result_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign step   = step_q;

`ifdef GATE_SEQ_SELF_CHECK_EN
   logic       err_q, err_d;
   logic [6:0] direct;

   // Reference built from plain operators, independent of the demux datapath.
   always_comb begin
      direct           = 7'b0000000;
      direct[IDX_AND]  = op_a_q & op_b_q;
      direct[IDX_NOT]  = ~op_a_q;
      direct[IDX_OR]   = op_a_q | op_b_q;
      direct[IDX_NAND] = ~(op_a_q & op_b_q);
      direct[IDX_NOR]  = ~(op_a_q | op_b_q);
      direct[IDX_XOR]  = op_a_q ^ op_b_q;
      direct[IDX_XNOR] = ~(op_a_q ^ op_b_q);
      err_d = err_q | (done_q && (result_q != direct));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gate_demux_sequencer.sv
// Directed + randomized bench for gate_demux_sequencer against a boolean reference model.
module tb_gate_demux_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       a = 1'b0;
   logic       b = 1'b0;
   logic       busy, done, err;
   logic [6:0] result;
   logic [3:0] step;

   int tests = 0;
   int fails = 0;

   gate_demux_sequencer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .step   (step),
      .err    (err)
   );

   always #5 clk = ~clk;

   // Reference: bit map [0]AND [1]NOT(a) [2]OR [3]NAND [4]NOR [5]XOR [6]XNOR.
   function automatic logic [6:0] ref_result(input logic ra, input logic rb);
      return {~(ra ^ rb), ra ^ rb, ~(ra | rb), ~(ra & rb), ra | rb, ~ra, ra & rb};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts one run; optionally disturbs a/b/start during EVAL. Returns the observed latency.
   task automatic run_op(input logic ra, input logic rb, input bit disturb,
                         output int lat, output logic [6:0] res);
      int cyc;
      @(negedge clk);
      a = ra; b = rb; start = 1'b1;
      cyc = 0;
      lat = -1;
      res = 'x;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            lat = cyc - 1;
            res = result;
            break;
         end
         if (disturb) begin
            start = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      logic [6:0] tt_exp [4];
      int lat;
      logic [6:0] res;
      logic [6:0] prev;
      int last_done;
      int seen;
      int ok;
      logic ra, rb;

      tt_exp[0] = 7'b1011010;
      tt_exp[1] = 7'b0101110;
      tt_exp[2] = 7'b0101100;
      tt_exp[3] = 7'b1000101;

      // Reset with arbitrary inputs; start must not be accepted while in reset.
      repeat (3) begin
         @(negedge clk);
         start = 1'b1;
         a = 1'($urandom_range(0, 1));
         b = 1'($urandom_range(0, 1));
      end
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_step", step, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_idle", busy, 0);

      // Truth table, fixed expectations and model agreement.
      for (int i = 0; i < 4; i++) begin
         run_op(1'(i >> 1), 1'(i), 1'b0, lat, res);
         check($sformatf("tt%0d_latency", i), lat, 10);
         check($sformatf("tt%0d_result", i), res, tt_exp[i]);
         check($sformatf("tt%0d_model", i), res, ref_result(1'(i >> 1), 1'(i)));
         @(negedge clk);
         check($sformatf("tt%0d_done_1cyc", i), done, 0);
         check($sformatf("tt%0d_hold", i), result, tt_exp[i]);
      end

      // Operand/start isolation: a=1,b=1 then disturb every cycle during EVAL.
      run_op(1'b1, 1'b1, 1'b1, lat, res);
      check("iso_latency", lat, 10);
      check("iso_result", res, 7'b1000101);
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) seen++;
      end
      check("iso_single_done", seen, 0);

      // Randomized runs with disturbance against the model.
      for (int i = 0; i < 10; i++) begin
         ra = 1'($urandom_range(0, 1));
         rb = 1'($urandom_range(0, 1));
         run_op(ra, rb, 1'b1, lat, res);
         check($sformatf("rnd%0d_latency", i), lat, 10);
         check($sformatf("rnd%0d_result", i), res, ref_result(ra, rb));
         repeat (2) @(negedge clk);
      end

      // Reset mid-run at step 4.
      prev = result;
      @(negedge clk);
      a = 1'b0; b = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 0;
      for (int c = 0; c < 20; c++) begin
         if (step == 4'd4) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      check("mid_reached_step4", ok, 1);
      rst_n = 1'b0;
      #1;
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_result", result, 0);
      check("mid_step", step, 0);
      check("mid_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      check("mid_no_done_after", seen, 0);
      check("mid_result_stays0", result, 0);

      // Back-to-back with start held high: done every 11 cycles, busy == !done.
      @(negedge clk);
      a = 1'b1; b = 1'b0; start = 1'b1;
      last_done = 0;
      seen = 0;
      ok = 1;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (busy === done) ok = 0;
         if (done) begin
            check($sformatf("b2b_period%0d", seen), c - last_done, 11);
            check($sformatf("b2b_result%0d", seen), result, 7'b0101100);
            last_done = c;
            seen++;
         end
      end
      check("b2b_busy_vs_done", ok, 1);
      check("b2b_done_count", seen, 4);
      start = 1'b0;
      ok = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            break;
         end
      end
      check("b2b_drain", ok, 1);
      repeat (2) @(negedge clk);
      check("b2b_idle", busy, 0);
      check("err_clean", err, 0);

`ifdef GATE_SEQ_SELF_CHECK_EN
      // Corrupt the partial result mid-run; the self-check must flag it and hold it.
      @(negedge clk);
      a = 1'b1; b = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (step == 4'd3) break;
         @(negedge clk);
      end
      force dut.res_q = 7'b0000000;
      @(negedge clk);
      release dut.res_q;
      repeat (15) @(negedge clk);
      check("sc_err_set", err, 1);
      repeat (5) @(negedge clk);
      check("sc_err_sticky", err, 1);
      rst_n = 1'b0;
      #1;
      check("sc_err_cleared", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gate_demux_sequencer.md
GATE_DEMUX_SEQUENCER -- requirements
Module: gate_demux_sequencer

Interface
REQ-001 SHALL have no parameters; step count and bit map are fixed constants.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request one evaluation; sampled on clk edge.
REQ-005 a  input  1  operand A; latched when start is accepted.
REQ-006 b  input  1  operand B; latched when start is accepted.
REQ-007 busy  output  1  high while evaluation is in progress (EVAL state).
REQ-008 done  output  1  one-cycle pulse; result valid and updated.
REQ-009 result  output  7  bit map [0]AND [1]NOT(a) [2]OR [3]NAND [4]NOR [5]XOR [6]XNOR.
REQ-010 step  output  4  current EVAL step index, debug; 0 outside EVAL.
REQ-011 err  output  1  self-check mismatch flag (see Configuration).

Function
REQ-012 SHALL compute all seven functions with exactly one shared demux1_4 instance (in tied 1), time-multiplexed; no direct gate operators on the datapath.
REQ-013 FSM states IDLE, EVAL, DONE; IDLE->EVAL on start; EVAL->DONE after step 8; DONE->IDLE, or DONE->EVAL if start is high in DONE.
REQ-014 Accepting start SHALL latch a, b into operand regs and clear step to 0; a, b changes thereafter SHALL have no effect on the run.
REQ-015 start while in EVAL SHALL be ignored (no queueing).
REQ-016 One step per cycle, demux sel / captured output: S0 {a,b} -> m[3:0] = out, AND = out[3]; S1 {a,0} -> NOT = out[0]; S2 {m[0],0} -> OR; S3 {m[3],0} -> NAND; S4 {OR,0} -> NOR; S5 {m[1],m[2]} -> t; S6 {t,0} -> XOR; S7 {m[0],m[3]} -> u; S8 {u,0} -> XNOR (S2-S8 capture out[0]).
REQ-017 Intermediate values (m, t, u, partial results) SHALL be held in internal scratch registers; result SHALL update only in the cycle done rises, all 7 bits together.
REQ-018 Latency: start sampled at edge N -> done=1 and new result during cycle after edge N+10.
REQ-019 result SHALL hold its last value until the next done; done SHALL be high for exactly one cycle per run.
REQ-020 In IDLE, demux sel SHALL be driven 2'b00.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, busy=0, done=0, result=0, step=0, err=0, and clear scratch and operand regs, including mid-EVAL.
REQ-022 start is not accepted while rst_n is low; first acceptance is on the first edge after release.

Configuration
REQ-023 Macro GATE_SEQ_SELF_CHECK_EN defined: in the done cycle, compare the assembled result with the seven functions computed directly from latched operands; on mismatch set err sticky until reset.
REQ-024 Macro undefined: err SHALL be tied to 0 and no comparison logic generated; all other behaviour identical.

Structure
REQ-025 Shared package gate_seq_pkg SHALL hold the FSM state encoding, NUM_STEPS=9, and result bit-index constants (IDX_AND..IDX_XNOR).
REQ-026 The sole sub-module SHALL be the existing demux1_4 (in, sel[1:0], out[3:0]); step decode and capture muxing stay in this module.

Verification
REQ-027 Reset: rst_n=0 with any inputs -> busy=0, done=0, result=7'b0000000, err=0.
REQ-028 Truth table: a,b = 00/01/10/11 with one start pulse each -> result 7'b1011010 / 7'b0101110 / 7'b0101100 / 7'b1000101, done exactly 10 cycles after start edge.
REQ-029 Operand/start isolation: start a=1,b=1, then toggle a, b and pulse start every cycle during EVAL -> single done, result=7'b1000101.
REQ-030 Reset mid-run: start a=0,b=0, assert rst_n at step 4 -> all outputs 0 at once; after release, no done until a new start.
REQ-031 Back-to-back: start held high continuously with a=1,b=0 -> done pulses every 11 cycles, result=7'b0101100, busy low only during DONE cycles.
REQ-032 Self-check build with GATE_SEQ_SELF_CHECK_EN: all four operand pairs -> err stays 0; forced scratch-register corruption -> err=1 until reset.
